// File: rtl/avmm_memtest_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | avmm_memtest_master_if : word-addressed Avalon-MM bus, master/slave views |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface avmm_memtest_master_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;
    logic                avm_waitrequest;

    modport master (
        output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/avmm_memtest_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | avmm_memtest_master : write-then-verify RAM tester on an Avalon-MM bus.    |
// | Optional AVMM_MEMTEST_LFSR_EN selects a Galois LFSR pattern over seed+i.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module avmm_memtest_master #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int ERR_W  = 16
) (
    input  wire                clk,
    input  wire                reset_n,
    input  wire                start,
    input  wire [ADDR_W-1:0]   base_addr,
    input  wire [ADDR_W:0]     num_words,
    input  wire [DATA_W-1:0]   seed,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [ADDR_W-1:0]  first_err_addr,
    output logic [DATA_W-1:0]  first_err_data,
    avmm_memtest_master_if.master avm
);

    localparam logic [ADDR_W:0]   C_IDX_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
    localparam logic [ERR_W-1:0]  C_ERR_ONE  = ERR_W'(1);
    localparam logic [DATA_W-1:0] C_DATA_ONE = DATA_W'(1);
`ifdef AVMM_MEMTEST_LFSR_EN
    localparam logic [DATA_W-1:0] C_LFSR_TAPS = DATA_W'(32'h8020_0003);
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_num;
    logic [ADDR_W:0]     r_idx;
    logic [DATA_W-1:0]   r_seed;
    logic [DATA_W-1:0]   r_pat;
    logic                w_last;
    logic [DATA_W-1:0]   w_pat_nxt;

    function automatic logic [DATA_W-1:0] pat_first(input logic [DATA_W-1:0] s);
`ifdef AVMM_MEMTEST_LFSR_EN
        return (s == '0) ? C_DATA_ONE : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] pat_step(input logic [DATA_W-1:0] p);
`ifdef AVMM_MEMTEST_LFSR_EN
        return (p >> 1) ^ (p[0] ? C_LFSR_TAPS : '0);
`else
        return p + C_DATA_ONE;
`endif
    endfunction

    // r_pat always holds pattern(r_idx); avm_address tracks base+r_idx modulo the address space
    assign w_last    = ((r_idx + C_IDX_ONE) == r_num);
    assign w_pat_nxt = pat_step(r_pat);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state            <= S_IDLE;
            r_base             <= '0;
            r_num              <= '0;
            r_idx              <= '0;
            r_seed             <= '0;
            r_pat              <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            err_count          <= '0;
            first_err_addr     <= '0;
            first_err_data     <= '0;
            avm.avm_address    <= '0;
            avm.avm_byteenable <= '0;
            avm.avm_read       <= 1'b0;
            avm.avm_write      <= 1'b0;
            avm.avm_writedata  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base         <= base_addr;
                        r_num          <= num_words;
                        r_seed         <= seed;
                        r_idx          <= '0;
                        r_pat          <= pat_first(seed);
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        if (num_words == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state            <= S_WR;
                            avm.avm_write      <= 1'b1;
                            avm.avm_byteenable <= '1;
                            avm.avm_address    <= base_addr;
                            avm.avm_writedata  <= pat_first(seed);
                        end
                    end
                end
                S_WR: begin
                    if (!avm.avm_waitrequest) begin
                        if (w_last) begin
                            r_idx             <= '0;
                            r_pat             <= pat_first(r_seed);
                            avm.avm_write     <= 1'b0;
                            avm.avm_writedata <= '0;
                            avm.avm_read      <= 1'b1;
                            avm.avm_address   <= r_base;
                            r_state           <= S_RD_REQ;
                        end else begin
                            r_idx             <= r_idx + C_IDX_ONE;
                            r_pat             <= w_pat_nxt;
                            avm.avm_address   <= avm.avm_address + C_ADDR_ONE;
                            avm.avm_writedata <= w_pat_nxt;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (!avm.avm_waitrequest) begin
                        avm.avm_read       <= 1'b0;
                        avm.avm_byteenable <= '0;
                        r_state            <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (avm.avm_readdatavalid) begin
                        if (avm.avm_readdata != r_pat) begin
                            if (err_count == '0) begin
                                first_err_addr <= avm.avm_address;
                                first_err_data <= avm.avm_readdata;
                            end
                            if (err_count != '1) begin
                                err_count <= err_count + C_ERR_ONE;
                            end
                        end
                        if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_idx              <= r_idx + C_IDX_ONE;
                            r_pat              <= w_pat_nxt;
                            avm.avm_address    <= avm.avm_address + C_ADDR_ONE;
                            avm.avm_read       <= 1'b1;
                            avm.avm_byteenable <= '1;
                            r_state            <= S_RD_REQ;
                        end
                    end
                end
                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    pass    <= (err_count == '0);
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avmm_memtest_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_avmm_memtest_master : RAM-model slave with stalls/corruption, random   |
// | and directed runs checked against a range/pattern reference. Rev 1.0       |
// +----------------------------------------------------------------------------+
module tb_avmm_memtest_master;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int ERR_W  = 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [ADDR_W:0]     num_words = '0;
    logic [DATA_W-1:0]   seed = '0;
    logic                busy;
    logic                done;
    logic                pass;
    logic [ERR_W-1:0]    err_count;
    logic [ADDR_W-1:0]   first_err_addr;
    logic [DATA_W-1:0]   first_err_data;

    avmm_memtest_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avmm_memtest_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data),
        .avm            (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: RAM with read latency 1, n_wait stall cycles per access,
    // optional corruption of one address on read, optional stray readdatavalid.
    int               n_wait = 0;
    bit               corrupt_en = 1'b0;
    logic [14:0]      corrupt_addr = '0;
    bit               stray_en = 1'b0;
    logic [31:0]      mem [0:32767];
    int               wait_cnt = 0;
    bit               stalled = 1'b0;
    logic [48:0]      snap = '0;
    int               wr_n = 0, rd_n = 0, stab_viol = 0, be_viol = 0, done_cnt = 0;
    logic [14:0]      wr_addr_log [0:4095];
    logic [31:0]      wr_data_log [0:4095];
    logic [14:0]      rd_addr_log [0:4095];
    logic             rdv = 1'b0;
    logic [31:0]      rdata = '0;

    assign bus.avm_readdatavalid = rdv;
    assign bus.avm_readdata      = rdata;
    assign bus.avm_waitrequest   = (bus.avm_read || bus.avm_write) && (wait_cnt < n_wait);

    always @(posedge clk) begin
        rdv <= 1'b0;
        if (!reset_n) begin
            wait_cnt <= 0;
            stalled  <= 1'b0;
        end else begin
            if (stalled && ({bus.avm_address, bus.avm_writedata, bus.avm_read, bus.avm_write} != snap))
                stab_viol++;
            if (stray_en && bus.avm_write && ($urandom_range(0, 1) == 1)) begin
                rdv   <= 1'b1;
                rdata <= $urandom;
            end
            if (bus.avm_read || bus.avm_write) begin
                if (bus.avm_byteenable != 4'hF) be_viol++;
                if (bus.avm_waitrequest) begin
                    wait_cnt <= wait_cnt + 1;
                    stalled  <= 1'b1;
                    snap     <= {bus.avm_address, bus.avm_writedata, bus.avm_read, bus.avm_write};
                end else begin
                    wait_cnt <= 0;
                    stalled  <= 1'b0;
                    if (bus.avm_write) begin
                        mem[bus.avm_address] = bus.avm_writedata;
                        wr_addr_log[wr_n % 4096] = bus.avm_address;
                        wr_data_log[wr_n % 4096] = bus.avm_writedata;
                        wr_n++;
                    end
                    if (bus.avm_read) begin
                        rd_addr_log[rd_n % 4096] = bus.avm_address;
                        rd_n++;
                        rdv   <= 1'b1;
                        rdata <= (corrupt_en && bus.avm_address == corrupt_addr) ?
                                 32'hDEAD_BEEF : mem[bus.avm_address];
                    end
                end
            end else begin
                wait_cnt <= 0;
                stalled  <= 1'b0;
            end
        end
    end

    always @(negedge clk) if (done) done_cnt++;

    // Reference pattern: word i of a run seeded with s
    function automatic logic [31:0] model_pat(input logic [31:0] s, input int i);
`ifdef AVMM_MEMTEST_LFSR_EN
        logic [31:0] x;
        x = (s == 32'd0) ? 32'd1 : s;
        for (int k = 0; k < i; k++) x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
        return x;
`else
        return s + 32'(i);
`endif
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " pass"}, pass, 0);
        check({tag, " err_count"}, err_count, 0);
        check({tag, " first_err_addr"}, first_err_addr, 0);
        check({tag, " first_err_data"}, first_err_data, 0);
        check({tag, " avm_read"}, bus.avm_read, 0);
        check({tag, " avm_write"}, bus.avm_write, 0);
        check({tag, " avm_address"}, bus.avm_address, 0);
        check({tag, " avm_byteenable"}, bus.avm_byteenable, 0);
        check({tag, " avm_writedata"}, bus.avm_writedata, 0);
    endtask

    task automatic run_test(input string name, input logic [14:0] b, input logic [15:0] n,
                            input logic [31:0] s, input int nw, input bit cen,
                            input logic [14:0] caddr, input bit poke, input bit stray,
                            input int exp_lat);
        int          wr0, rd0, sv0, bv0, cyc, bad_wr, bad_rd, exp_err, nwr, nrd;
        logic [14:0] exp_faddr, a;
        logic [31:0] d;
        bit          got_done;
        n_wait = nw; corrupt_en = cen; corrupt_addr = caddr; stray_en = stray;
        @(negedge clk);
        wr0 = wr_n; rd0 = rd_n; sv0 = stab_viol; bv0 = be_viol;
        base_addr = b; num_words = n; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = 15'($urandom); num_words = 16'($urandom); seed = $urandom;
        check({name, " busy_after_start"}, busy, 1);
        cyc = 1; got_done = 1'b0;
        while (!got_done && cyc < 3000) begin
            start = (poke && cyc == 4);
            if (start) begin
                base_addr = 15'($urandom); num_words = 16'($urandom_range(1, 40)); seed = $urandom;
            end
            @(negedge clk);
            cyc++;
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        check({name, " done_seen"}, got_done, 1);
        if (exp_lat > 0) check({name, " latency"}, cyc, exp_lat);

        exp_err = 0; exp_faddr = '0;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 15'(i);
            d = model_pat(s, i);
            if (cen && a == caddr && d != 32'hDEAD_BEEF) begin
                if (exp_err == 0) exp_faddr = a;
                exp_err++;
            end
        end
        check({name, " err_count"}, err_count, exp_err);
        check({name, " pass"}, pass, (exp_err == 0));
        check({name, " first_err_addr"}, first_err_addr, exp_err > 0 ? exp_faddr : 15'd0);
        check({name, " first_err_data"}, first_err_data, exp_err > 0 ? 32'hDEAD_BEEF : 32'd0);

        @(negedge clk);
        check({name, " done_one_cycle"}, done, 0);
        check({name, " idle_busy"}, busy, 0);
        repeat (3) @(negedge clk);

        nwr = wr_n - wr0; nrd = rd_n - rd0;
        check({name, " write_count"}, nwr, n);
        check({name, " read_count"}, nrd, n);
        bad_wr = 0; bad_rd = 0;
        for (int i = 0; i < int'(n) && i < nwr; i++) begin
            if (wr_addr_log[(wr0 + i) % 4096] !== b + 15'(i) ||
                wr_data_log[(wr0 + i) % 4096] !== model_pat(s, i)) bad_wr++;
        end
        for (int i = 0; i < int'(n) && i < nrd; i++) begin
            if (rd_addr_log[(rd0 + i) % 4096] !== b + 15'(i)) bad_rd++;
        end
        check({name, " write_contents_bad"}, bad_wr, 0);
        check({name, " read_addrs_bad"}, bad_rd, 0);
        check({name, " stall_stability_viol"}, stab_viol - sv0, 0);
        check({name, " byteenable_viol"}, be_viol - bv0, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc0;
        logic [14:0] rb;
        logic [15:0] rn;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset_n = 1'b1;

        run_test("basic",   15'h0010, 16'd8, 32'h0000_1000, 0, 1'b0, 15'h0,    1'b0, 1'b0, 26);
        run_test("stall",   15'h0010, 16'd8, 32'h0000_1000, 2, 1'b0, 15'h0,    1'b1, 1'b0, 0);
        run_test("corrupt", 15'h0010, 16'd8, 32'h0000_1000, 0, 1'b1, 15'h0013, 1'b0, 1'b0, 0);
        run_test("wrap",    15'h7FFE, 16'd4, 32'hA5A5_0000, 1, 1'b0, 15'h0,    1'b0, 1'b1, 0);
        run_test("zero",    15'h0200, 16'd0, 32'h0000_1234, 0, 1'b0, 15'h0,    1'b0, 1'b0, 2);

        // Reset in the middle of the write pass
        n_wait = 0; stray_en = 1'b0; corrupt_en = 1'b0;
        @(negedge clk);
        base_addr = 15'h0100; num_words = 16'd20; seed = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid write_active", bus.avm_write, 1);
        dc0 = done_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid avm_write", bus.avm_write, 0);
        check("rst_mid busy", busy, 0);
        repeat (2) @(negedge clk);
        check_reset_state("rst_mid");
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid no_done", done_cnt - dc0, 0);

        for (int k = 0; k < 8; k++) begin
            rb = ($urandom_range(0, 1) == 1) ? 15'(15'h7FF0 + $urandom_range(0, 15)) : 15'($urandom);
            rn = 16'($urandom_range(1, 24));
            run_test($sformatf("rand%0d", k), rb, rn, $urandom, $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 15'(rb + 15'($urandom_range(0, int'(rn) - 1))),
                     1'($urandom_range(0, 1)), 1'b1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
